// File: rtl/ahb3lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_pkg: AHB3-Lite encodings, request length codes and master FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] HPROT_RESET = 4'b0011;

  localparam logic [1:0] REQ_LEN_SINGLE = 2'd0;
  localparam logic [1:0] REQ_LEN_INCR4  = 2'd1;
  localparam logic [1:0] REQ_LEN_INCR8  = 2'd2;
  localparam logic [1:0] REQ_LEN_INCR16 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ERR1 = 2'd2
  } mst_state_e;

  function automatic logic [2:0] len2hburst(input logic [1:0] len);
    case (len)
      REQ_LEN_INCR4:  return HBURST_INCR4;
      REQ_LEN_INCR8:  return HBURST_INCR8;
      REQ_LEN_INCR16: return HBURST_INCR16;
      default:        return HBURST_SINGLE;
    endcase
  endfunction

  // Beat counter preload: number of beats minus one.
  function automatic logic [3:0] len2cnt(input logic [1:0] len);
    case (len)
      REQ_LEN_INCR4:  return 4'd3;
      REQ_LEN_INCR8:  return 4'd7;
      REQ_LEN_INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb3lite_mst_addrgen.sv
// ----------------------------------------------------------------------------
// ahb3lite_mst_addrgen: beat counter, next-address incrementer, last-beat flag.
// Counter present only with AHB3LITE_MST_BURST_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb3lite_mst_addrgen
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  load_i,
  input  logic [1:0]            len_i,
  input  logic                  advance_i,
  input  logic [HADDR_SIZE-1:0] addr_i,
  input  logic [2:0]            size_i,
  output logic [HADDR_SIZE-1:0] addr_next_o,
  output logic                  last_o
);

  assign addr_next_o = addr_i + (HADDR_SIZE'(1) << size_i);

`ifdef AHB3LITE_MST_BURST_EN
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)         cnt_d = len2cnt(len_i);
    else if (advance_i) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == 4'd0);
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{HCLK, HRESETn, load_i, len_i, advance_i};
  assign last_o      = 1'b1;
`endif

endmodule

`default_nettype wire

// File: rtl/ahb3lite_mst_port.sv
// ----------------------------------------------------------------------------
// ahb3lite_mst_port: request/response port to pipelined AHB3-Lite master.
// INCR4/8/16 bursts enabled by defining AHB3LITE_MST_BURST_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb3lite_mst_port
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic                  req_i,
  output logic                  req_ack_o,
  input  logic                  req_write_i,
  input  logic [HADDR_SIZE-1:0] req_addr_i,
  input  logic [2:0]            req_size_i,
  input  logic [3:0]            req_prot_i,
  input  logic [1:0]            req_len_i,
  output logic                  wdata_req_o,
  input  logic [HDATA_SIZE-1:0] wdata_i,
  output logic                  rsp_valid_o,
  output logic [HDATA_SIZE-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_last_o
);

  mst_state_e            state_q, state_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [3:0]            hprot_q, hprot_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic                  dp_last_q, dp_last_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_last_q, rsp_last_d;

  logic                  last;
  logic [HADDR_SIZE-1:0] addr_next;
  logic [2:0]            hburst_req;
  logic                  addr_done, dp_done, err_first, err_done, advance;

  assign addr_done = (state_q == ST_ADDR) & HREADY;
  assign dp_done   = dp_valid_q & HREADY;
  assign err_first = dp_valid_q & HRESP & ~HREADY & (state_q != ST_ERR1);
  assign err_done  = dp_done & HRESP;
  assign advance   = addr_done & ~last & ~err_done;

  assign req_ack_o   = req_i & HREADY &
                       ((state_q == ST_IDLE) | ((state_q == ST_ADDR) & last));
  assign wdata_req_o = addr_done & hwrite_q;

`ifdef AHB3LITE_MST_BURST_EN
  assign hburst_req = len2hburst(req_len_i);
`else
  assign hburst_req = HBURST_SINGLE;
`endif

  ahb3lite_mst_addrgen #(
    .HADDR_SIZE (HADDR_SIZE)
  ) u_addrgen (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .load_i      (req_ack_o),
    .len_i       (req_len_i),
    .advance_i   (advance),
    .addr_i      (haddr_q),
    .size_i      (hsize_q),
    .addr_next_o (addr_next),
    .last_o      (last)
  );

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hburst_d    = hburst_q;
    hprot_d     = hprot_q;
    hwdata_d    = hwdata_q;
    dp_valid_d  = dp_valid_q & ~HREADY;
    dp_write_d  = dp_write_q;
    dp_last_d   = dp_last_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    if (dp_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = HRESP;
      rsp_last_d  = dp_last_q | HRESP;
      if (!dp_write_q) rsp_rdata_d = HRDATA;
    end

    if (addr_done) begin
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      dp_last_d  = last;
      if (hwrite_q) hwdata_d = wdata_i;
    end

    case (state_q)
      ST_IDLE, ST_ADDR: begin
        if (err_first) begin
          // Cancel whatever is pending in the address phase.
          state_d  = ST_ERR1;
          htrans_d = HTRANS_IDLE;
        end else if (req_ack_o) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = req_addr_i;
          hwrite_d = req_write_i;
          hsize_d  = req_size_i;
          hprot_d  = req_prot_i;
          hburst_d = hburst_req;
        end else if (err_done) begin
          state_d    = ST_IDLE;
          htrans_d   = HTRANS_IDLE;
          dp_valid_d = 1'b0;
        end else if (addr_done) begin
          if (last) begin
            state_d  = ST_IDLE;
            htrans_d = HTRANS_IDLE;
          end else begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = addr_next;
          end
        end
      end
      ST_ERR1: begin
        htrans_d = HTRANS_IDLE;
        if (HREADY) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_WORD;
      hburst_q    <= HBURST_SINGLE;
      hprot_q     <= HPROT_RESET;
      hwdata_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hburst_q    <= hburst_d;
      hprot_q     <= hprot_d;
      hwdata_q    <= hwdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_last_q   <= dp_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign HTRANS      = htrans_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HPROT       = hprot_q;
  assign HWDATA      = hwdata_q;
  assign HMASTLOCK   = 1'b0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_last_o  = rsp_last_q;

`ifndef SYNTHESIS
  // A SEQ beat landing on a 1KB boundary means the requester's burst crossed it.
  a_no_1kb_cross: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (htrans_q == HTRANS_SEQ) |-> (haddr_q[9:0] != 10'd0))
    else $error("burst crossed a 1KB boundary");
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_mst_port.sv
// ----------------------------------------------------------------------------
// tb_ahb3lite_mst_port: directed self-checking bench for ahb3lite_mst_port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ahb3lite_mst_port;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        req_i, req_ack_o, req_write_i;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [3:0]  req_prot_i;
  logic [1:0]  req_len_i;
  logic        wdata_req_o;
  logic [31:0] wdata_i;
  logic        rsp_valid_o, rsp_err_o, rsp_last_o;
  logic [31:0] rsp_rdata_o;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_mst_port #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
    .req_i(req_i), .req_ack_o(req_ack_o), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_prot_i(req_prot_i), .req_len_i(req_len_i),
    .wdata_req_o(wdata_req_o), .wdata_i(wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o)
  );

  task automatic idle_inputs();
    req_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] prot,
                       input logic [1:0] len);
    req_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_size_i = 3'd2;
    req_prot_i = prot; req_len_i = len;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; idle_inputs(); wdata_i = 32'h0;
    req_write_i = 1'b0; req_addr_i = 32'h0; req_size_i = 3'd2; req_prot_i = 4'h0; req_len_i = 2'd0;
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR, HWDATA} !== {2'b00, 32'h0, 32'h0}) begin failures++;
      $display("FAIL reset_bus act=%0h exp=0", {HTRANS, HADDR, HWDATA}); end
    checks++; if ({HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK} !== {1'b0, 3'b010, 3'b000, 4'b0011, 1'b0}) begin
      failures++; $display("FAIL reset_ctrl act=%0h exp=%0h", {HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK},
      {1'b0, 3'b010, 3'b000, 4'b0011, 1'b0}); end
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_last_o, rsp_rdata_o} !== 35'h0) begin failures++;
      $display("FAIL reset_rsp act=%0h exp=0", {rsp_valid_o, rsp_err_o, rsp_last_o, rsp_rdata_o}); end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_single_write();
    @(negedge HCLK);
    issue(1'b1, 32'h1000, 4'b0010, 2'd0);
    #1; checks++; if (req_ack_o !== 1'b1) begin failures++; $display("FAIL wr_ack act=%0b exp=1", req_ack_o); end
    @(negedge HCLK);
    req_i = 1'b0; wdata_i = 32'hDEADBEEF;
    checks++; if ({HTRANS, HADDR, HWRITE, HSIZE, HPROT} !== {2'b10, 32'h1000, 1'b1, 3'd2, 4'b0010}) begin
      failures++; $display("FAIL wr_addr_phase act=%0h exp=%0h", {HTRANS, HADDR, HWRITE, HSIZE, HPROT},
      {2'b10, 32'h1000, 1'b1, 3'd2, 4'b0010}); end
    #1; checks++; if (wdata_req_o !== 1'b1) begin failures++; $display("FAIL wr_wdata_req act=%0b exp=1", wdata_req_o); end
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hwdata act=%0h exp=deadbeef", HWDATA); end
    checks++; if ({HTRANS, rsp_valid_o} !== 3'b000) begin failures++;
      $display("FAIL wr_idle_c2 act=%0h exp=0", {HTRANS, rsp_valid_o}); end
    @(negedge HCLK);
    checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o} !== 3'b110) begin failures++;
      $display("FAIL wr_rsp act=%0b exp=110", {rsp_valid_o, rsp_last_o, rsp_err_o}); end
    @(negedge HCLK);
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wr_rsp_pulse act=%0b exp=0", rsp_valid_o); end
  endtask

  task automatic test_wait_read();
    @(negedge HCLK);
    issue(1'b0, 32'h2004, 4'b0011, 2'd0);
    #1; checks++; if (req_ack_o !== 1'b1) begin failures++; $display("FAIL rd_ack act=%0b exp=1", req_ack_o); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge HCLK);
      req_i  = 1'b0;
      HREADY = (c >= 3);
      HRDATA = (c == 4) ? 32'h12345678 : 32'hFFFF0000;
      if (c <= 3) begin
        checks++; if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h2004, 1'b0}) begin failures++;
          $display("FAIL rd_addr_hold c=%0d act=%0h exp=%0h", c, {HTRANS, HADDR, HWRITE}, {2'b10, 32'h2004, 1'b0}); end
      end
      if (c == 4) begin
        checks++; if ({HTRANS, rsp_valid_o} !== 3'b000) begin failures++;
          $display("FAIL rd_c4 act=%0h exp=0", {HTRANS, rsp_valid_o}); end
      end
      if (c == 5) begin
        checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o, rsp_rdata_o} !== {3'b110, 32'h12345678}) begin
          failures++; $display("FAIL rd_rsp act=%0h exp=%0h", {rsp_valid_o, rsp_last_o, rsp_err_o, rsp_rdata_o},
          {3'b110, 32'h12345678}); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge HCLK);
    issue(1'b1, 32'h10, 4'b0011, 2'd0);
    #1; checks++; if (req_ack_o !== 1'b1) begin failures++; $display("FAIL b2b_ack0 act=%0b exp=1", req_ack_o); end
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h10}) begin failures++;
      $display("FAIL b2b_c1 act=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 32'h10}); end
    issue(1'b0, 32'h14, 4'b0011, 2'd0); wdata_i = 32'hA5A50010;
    #1; checks++; if ({req_ack_o, wdata_req_o} !== 2'b11) begin failures++;
      $display("FAIL b2b_ack1 act=%0b exp=11", {req_ack_o, wdata_req_o}); end
    @(negedge HCLK);
    req_i = 1'b0;
    checks++; if ({HTRANS, HADDR, HWRITE, HWDATA} !== {2'b10, 32'h14, 1'b0, 32'hA5A50010}) begin failures++;
      $display("FAIL b2b_c2 act=%0h exp=%0h", {HTRANS, HADDR, HWRITE, HWDATA}, {2'b10, 32'h14, 1'b0, 32'hA5A50010}); end
    @(negedge HCLK);
    HRDATA = 32'hCAFE0014;
    checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o, HTRANS} !== 5'b11000) begin failures++;
      $display("FAIL b2b_rsp_wr act=%0b exp=11000", {rsp_valid_o, rsp_last_o, rsp_err_o, HTRANS}); end
    @(negedge HCLK);
    checks++; if ({rsp_valid_o, rsp_last_o, rsp_rdata_o} !== {2'b11, 32'hCAFE0014}) begin failures++;
      $display("FAIL b2b_rsp_rd act=%0h exp=%0h", {rsp_valid_o, rsp_last_o, rsp_rdata_o}, {2'b11, 32'hCAFE0014}); end
    idle_inputs();
  endtask

`ifdef AHB3LITE_MST_BURST_EN
  task automatic test_incr4();
    logic [1:0] exp_trans;
    @(negedge HCLK);
    issue(1'b0, 32'h100, 4'b0011, 2'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge HCLK);
      req_i = 1'b0;
      HRDATA = 32'hB0000000 + 32'(c - 1);
      exp_trans = (c == 1) ? 2'b10 : ((c <= 4) ? 2'b11 : 2'b00);
      checks++; if (HTRANS !== exp_trans) begin failures++;
        $display("FAIL incr4_htrans c=%0d act=%0h exp=%0h", c, HTRANS, exp_trans); end
      if (c <= 4) begin
        checks++; if ({HADDR, HBURST} !== {32'h100 + 32'(4 * (c - 1)), 3'b011}) begin failures++;
          $display("FAIL incr4_haddr c=%0d act=%0h exp=%0h", c, {HADDR, HBURST}, {32'h100 + 32'(4 * (c - 1)), 3'b011}); end
      end
      if (c >= 3) begin
        checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o, rsp_rdata_o} !== {1'b1, c == 6, 1'b0, 32'hB0000000 + 32'(c - 2)}) begin
          failures++; $display("FAIL incr4_rsp c=%0d act=%0h exp=%0h", c, {rsp_valid_o, rsp_last_o, rsp_err_o, rsp_rdata_o},
          {1'b1, c == 6, 1'b0, 32'hB0000000 + 32'(c - 2)}); end
      end else begin
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL incr4_norsp c=%0d act=%0b exp=0", c, rsp_valid_o); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_error();
    @(negedge HCLK);
    issue(1'b1, 32'h200, 4'b0011, 2'd2);
    #1; checks++; if (req_ack_o !== 1'b1) begin failures++; $display("FAIL err_ack act=%0b exp=1", req_ack_o); end
    @(negedge HCLK);
    req_i = 1'b0; wdata_i = 32'h11110001;
    checks++; if ({HTRANS, HBURST} !== {2'b10, 3'b101}) begin failures++;
      $display("FAIL err_c1 act=%0h exp=%0h", {HTRANS, HBURST}, {2'b10, 3'b101}); end
    #1; checks++; if (wdata_req_o !== 1'b1) begin failures++; $display("FAIL err_wreq1 act=%0b exp=1", wdata_req_o); end
    @(negedge HCLK);
    wdata_i = 32'h11110002;
    checks++; if ({HTRANS, HADDR, HWDATA} !== {2'b11, 32'h204, 32'h11110001}) begin failures++;
      $display("FAIL err_c2 act=%0h exp=%0h", {HTRANS, HADDR, HWDATA}, {2'b11, 32'h204, 32'h11110001}); end
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR, rsp_valid_o, rsp_err_o, rsp_last_o} !== {2'b11, 32'h208, 3'b100}) begin failures++;
      $display("FAIL err_c3 act=%0h exp=%0h", {HTRANS, HADDR, rsp_valid_o, rsp_err_o, rsp_last_o}, {2'b11, 32'h208, 3'b100}); end
    HREADY = 1'b0; HRESP = 1'b1;
    #1; checks++; if (wdata_req_o !== 1'b0) begin failures++; $display("FAIL err_wreq3 act=%0b exp=0", wdata_req_o); end
    @(negedge HCLK);
    checks++; if ({HTRANS, rsp_valid_o} !== 3'b000) begin failures++;
      $display("FAIL err_cancel act=%0h exp=0", {HTRANS, rsp_valid_o}); end
    HREADY = 1'b1; HRESP = 1'b1; issue(1'b1, 32'h400, 4'b0011, 2'd0);
    #1; checks++; if ({req_ack_o, wdata_req_o} !== 2'b00) begin failures++;
      $display("FAIL err_noack act=%0b exp=00", {req_ack_o, wdata_req_o}); end
    @(negedge HCLK);
    req_i = 1'b0; HRESP = 1'b0;
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_last_o, HTRANS} !== 5'b11100) begin failures++;
      $display("FAIL err_rsp act=%0b exp=11100", {rsp_valid_o, rsp_err_o, rsp_last_o, HTRANS}); end
    @(negedge HCLK);
    checks++; if ({rsp_valid_o, HTRANS, wdata_req_o} !== 4'b0000) begin failures++;
      $display("FAIL err_after act=%0b exp=0000", {rsp_valid_o, HTRANS, wdata_req_o}); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    issue(1'b0, 32'h100, 4'b0011, 2'd1);
    @(negedge HCLK); req_i = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR} !== {2'b11, 32'h108}) begin failures++;
      $display("FAIL rstmid_beat3 act=%0h exp=%0h", {HTRANS, HADDR}, {2'b11, 32'h108}); end
`else
  task automatic test_len_ignored();
    @(negedge HCLK);
    issue(1'b0, 32'h40, 4'b0011, 2'd3);
    @(negedge HCLK); req_i = 1'b0;
    checks++; if ({HTRANS, HADDR, HBURST} !== {2'b10, 32'h40, 3'b000}) begin failures++;
      $display("FAIL single_c1 act=%0h exp=%0h", {HTRANS, HADDR, HBURST}, {2'b10, 32'h40, 3'b000}); end
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL single_c2 act=%0h exp=0", HTRANS); end
    @(negedge HCLK);
    checks++; if ({rsp_valid_o, rsp_last_o} !== 2'b11) begin failures++;
      $display("FAIL single_rsp act=%0b exp=11", {rsp_valid_o, rsp_last_o}); end
  endtask

  task automatic test_error();
    @(negedge HCLK);
    issue(1'b1, 32'h300, 4'b0011, 2'd0);
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h300}) begin failures++;
      $display("FAIL err_c1 act=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 32'h300}); end
    issue(1'b1, 32'h304, 4'b0011, 2'd0); wdata_i = 32'h00000300;
    #1; checks++; if ({req_ack_o, wdata_req_o} !== 2'b11) begin failures++;
      $display("FAIL err_ack1 act=%0b exp=11", {req_ack_o, wdata_req_o}); end
    @(negedge HCLK);
    req_i = 1'b0;
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h304}) begin failures++;
      $display("FAIL err_c2 act=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 32'h304}); end
    HREADY = 1'b0; HRESP = 1'b1;
    #1; checks++; if (wdata_req_o !== 1'b0) begin failures++; $display("FAIL err_wreq2 act=%0b exp=0", wdata_req_o); end
    @(negedge HCLK);
    checks++; if ({HTRANS, rsp_valid_o} !== 3'b000) begin failures++;
      $display("FAIL err_cancel act=%0h exp=0", {HTRANS, rsp_valid_o}); end
    HREADY = 1'b1; HRESP = 1'b1; issue(1'b1, 32'h400, 4'b0011, 2'd0);
    #1; checks++; if ({req_ack_o, wdata_req_o} !== 2'b00) begin failures++;
      $display("FAIL err_noack act=%0b exp=00", {req_ack_o, wdata_req_o}); end
    @(negedge HCLK);
    req_i = 1'b0; HRESP = 1'b0;
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_last_o, HTRANS} !== 5'b11100) begin failures++;
      $display("FAIL err_rsp act=%0b exp=11100", {rsp_valid_o, rsp_err_o, rsp_last_o, HTRANS}); end
    @(negedge HCLK);
    checks++; if ({rsp_valid_o, HTRANS} !== 3'b000) begin failures++;
      $display("FAIL err_after act=%0b exp=000", {rsp_valid_o, HTRANS}); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    issue(1'b0, 32'h80, 4'b0011, 2'd0);
    @(negedge HCLK); req_i = 1'b0;
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h80}) begin failures++;
      $display("FAIL rstmid_beat act=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 32'h80}); end
`endif
    HRESETn = 1'b0;
    #1; checks++; if ({HTRANS, HADDR, rsp_valid_o} !== 35'h0) begin failures++;
      $display("FAIL rstmid_async act=%0h exp=0", {HTRANS, HADDR, rsp_valid_o}); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      checks++; if ({HTRANS, rsp_valid_o} !== 3'b000) begin failures++;
        $display("FAIL rstmid_quiet c=%0d act=%0h exp=0", c, {HTRANS, rsp_valid_o}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
`ifdef AHB3LITE_MST_BURST_EN
    test_incr4();
`else
    test_len_ignored();
`endif
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
